// File: rtl/edp_ctl_pkg.sv
// Shared EBOX control encodings: sequencer states, adder functions,
// MQ shift-register functions and AR/ADA/ADB source selects.
package edp_ctl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_STEP,
        S_FIXUP,
        S_DONE
    } state_e;

    // Adder function codes (octal, as written in the microcode listings)
    localparam logic [5:0] ADF_NONE = 6'o00;
    localparam logic [5:0] ADF_A    = 6'o37;  // pass A
    localparam logic [5:0] ADF_APB  = 6'o06;  // A + B
    localparam logic [5:0] ADF_AMB  = 6'o51;  // A - B
    localparam logic [5:0] ADF_AGEB = 6'o71;  // carry out = (A >= B)

    // MQ shift-register functions
    localparam logic [1:0] MQ_LOAD = 2'b00;
    localparam logic [1:0] MQ_SHL  = 2'b01;
    localparam logic [1:0] MQ_SHR  = 2'b10;
    localparam logic [1:0] MQ_HOLD = 2'b11;

    // AR source selects (same code drives ARL and ARR)
    localparam logic [2:0] AR_SEL_NONE = 3'b000;
    localparam logic [2:0] AR_SEL_AD   = 3'b010;
    localparam logic [2:0] AR_SEL_ADX2 = 3'b101;  // AD shifted left

    // Adder input selects
    localparam logic [1:0] ADA_AR   = 2'b00;
    localparam logic [1:0] ADB_NONE = 2'b00;
    localparam logic [1:0] ADB_BR   = 2'b10;
    localparam logic [1:0] ADB_BR2  = 2'b01;

endpackage

// File: rtl/edp_step_counter.sv
// Remaining-step counter: clear beats load beats decrement; saturates at 0.
module edp_step_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count; a decrement at zero holds so the count never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/edp_muldiv_seq.sv
// Multiply / non-restoring divide microsequencer for the EBOX data path.
// Owns the adder, AR/BR and MQ controls from start until the done pulse.
// CNT_W must be wide enough to hold STEPS-1.
module edp_muldiv_seq
    import edp_ctl_pkg::*;
#(
    parameter int STEPS = 36,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic             abort,
    input  logic             mq35,
    input  logic             ad_sign,
    input  logic             ad_cry0,
    output logic [5:0]       ad_func,
    output logic [1:0]       ada_sel,
    output logic [1:0]       adb_sel,
    output logic [2:0]       ar_sel,
    output logic             ar_load,
    output logic             arx_load,
    output logic             br_load,
    output logic             brx_load,
    output logic [1:0]       mq_sel,
    output logic             busy,
    output logic             done,
    output logic             div_ovf,
    output logic [CNT_W-1:0] step_cnt
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS - 1);

    state_e state_q;
    logic   op_div_q;
    logic   sign_q;      // sign of the previous divide step's AD result
    logic   busy_q;
    logic   done_q;
    logic   div_ovf_q;
    logic   cnt_zero;
    logic   cnt_clr, cnt_load, cnt_dec;

    // Abort and the DONE state both leave the counter reading 0 in IDLE
    assign cnt_clr  = abort || (state_q == S_DONE);
    assign cnt_load = (state_q == S_LOAD);
    assign cnt_dec  = (state_q == S_STEP);

    edp_step_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (CNT_INIT),
        .dec_i      (cnt_dec),
        .cnt_o      (step_cnt),
        .zero_o     (cnt_zero)
    );

    // Sequencer state, status flags and registered busy/done/overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_div_q  <= 1'b0;
            sign_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div_ovf_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                // Cancel: no done pulse, overflow status untouched
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            op_div_q  <= op_div;
                            div_ovf_q <= 1'b0;
                            busy_q    <= 1'b1;
                            state_q   <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        sign_q  <= 1'b0;
                        state_q <= op_div_q ? S_CHECK : S_STEP;
                    end
                    S_CHECK: begin
                        if (ad_cry0) begin
                            div_ovf_q <= 1'b1;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            state_q <= S_STEP;
                        end
                    end
                    S_STEP: begin
                        if (op_div_q)
                            sign_q <= ad_sign;
                        if (cnt_zero) begin
                            if (op_div_q) begin
                                state_q <= S_FIXUP;
                            end else begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        end
                    end
                    S_FIXUP: begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Data-path controls decoded from state; mq35 and abort are the only live inputs
    always_comb begin
        ad_func  = ADF_NONE;
        ada_sel  = ADA_AR;
        adb_sel  = ADB_NONE;
        ar_sel   = AR_SEL_NONE;
        ar_load  = 1'b0;
        arx_load = 1'b0;
        br_load  = 1'b0;
        brx_load = 1'b0;
        mq_sel   = MQ_HOLD;
        case (state_q)
            S_LOAD: begin
                br_load  = 1'b1;
                brx_load = 1'b1;
            end
            S_CHECK: begin
                ad_func = ADF_AGEB;
                adb_sel = ADB_BR;
            end
            S_STEP: begin
                adb_sel = ADB_BR;
                ar_load = 1'b1;
                if (op_div_q) begin
                    // Non-restoring: add back after a negative partial remainder
                    ad_func = sign_q ? ADF_APB : ADF_AMB;
                    ar_sel  = AR_SEL_ADX2;
                    mq_sel  = MQ_SHL;
                end else begin
                    ad_func = mq35 ? ADF_APB : ADF_A;
                    ar_sel  = AR_SEL_AD;
                    mq_sel  = MQ_SHR;
                end
            end
            S_FIXUP: begin
                // Restore a negative final remainder
                if (sign_q) begin
                    ad_func = ADF_APB;
                    adb_sel = ADB_BR;
                    ar_sel  = AR_SEL_AD;
                    ar_load = 1'b1;
                end
            end
            default: ;
        endcase
        if (abort) begin
            ar_load  = 1'b0;
            arx_load = 1'b0;
            br_load  = 1'b0;
            brx_load = 1'b0;
            mq_sel   = MQ_HOLD;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign div_ovf = div_ovf_q;

endmodule

// File: tb/tb_edp_muldiv_seq.sv
// Directed bench for edp_muldiv_seq: a table of whole operations checked
// cycle by cycle, plus hand sequences for reset, abort and start/abort races.
module tb_edp_muldiv_seq;

    logic       clk, rst_n, start, op_div, abort, mq35, ad_sign, ad_cry0;
    logic [5:0] ad_func;
    logic [1:0] ada_sel, adb_sel, mq_sel;
    logic [2:0] ar_sel;
    logic       ar_load, arx_load, br_load, brx_load, busy, done, div_ovf;
    logic [5:0] step_cnt;

    int total = 0;
    int bad   = 0;

    edp_muldiv_seq #(.STEPS(36), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_div(op_div), .abort(abort),
        .mq35(mq35), .ad_sign(ad_sign), .ad_cry0(ad_cry0),
        .ad_func(ad_func), .ada_sel(ada_sel), .adb_sel(adb_sel), .ar_sel(ar_sel),
        .ar_load(ar_load), .arx_load(arx_load), .br_load(br_load), .brx_load(brx_load),
        .mq_sel(mq_sel), .busy(busy), .done(done), .div_ovf(div_ovf), .step_cnt(step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit    op_div;
        int    mq_mode;   // 0 all 0, 1 all 1, 2 alternating starting with 1
        bit    cry;       // ad_cry0 value presented in CHECK
        int    sg_mode;   // 0 all 0, 1 all 1, 2 only last step 1, 3 alternating starting with 1
        int    lat;       // cycles from start to done
        int    nar;       // ar_load cycles
        int    napb;      // cycles with ar_load and ad_func = 06
        bit    ovf;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit mq_pat(input int m, input int k);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            default: return (k % 2) == 0;
        endcase
    endfunction

    function automatic bit sg_pat(input int m, input int k);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return k == 35;
            default: return (k % 2) == 0;
        endcase
    endfunction

    // One full operation; expected controls come from the step index the bench tracks
    task automatic run_op(input vec_t v);
        int lat, nar, napb, nbr, err, first_bad, k;
        int ovf_at_done;
        logic [5:0] ef;
        logic       eal;
        logic [1:0] emq;
        logic       ebusy;
        lat = -1; nar = 0; napb = 0; nbr = 0; err = 0; first_bad = -1; ovf_at_done = -1;
        for (int c = 0; c < 60 && lat < 0; c++) begin
            tick();
            start   = (c == 0);
            op_div  = v.op_div;
            ad_cry0 = v.cry;
            mq35    = (!v.op_div && c >= 2 && c <= 37) ? mq_pat(v.mq_mode, c - 2) : 1'b0;
            ad_sign = (v.op_div && c >= 3 && c <= 38) ? sg_pat(v.sg_mode, c - 3) : 1'b0;
            #1;
            ef = 6'o00; eal = 1'b0; emq = 2'b11;
            if (!v.op_div) begin
                if (c >= 2 && c <= 37) begin
                    ef = mq35 ? 6'o06 : 6'o37; eal = 1'b1; emq = 2'b10;
                end
            end else if (c == 2) begin
                ef = 6'o71;
            end else if (!v.cry && c >= 3 && c <= 38) begin
                k  = c - 3;
                ef = (k > 0 && sg_pat(v.sg_mode, k - 1)) ? 6'o06 : 6'o51;
                eal = 1'b1; emq = 2'b01;
            end else if (!v.cry && c == 39 && sg_pat(v.sg_mode, 35)) begin
                ef = 6'o06; eal = 1'b1;
            end
            ebusy = (c >= 1 && c < v.lat);
            if (ad_func !== ef || ar_load !== eal || mq_sel !== emq || busy !== ebusy ||
                done !== (c == v.lat) || brx_load !== (c == 1) || arx_load !== 1'b0) begin
                err++;
                if (first_bad < 0) first_bad = c;
            end
            if (ar_load) nar++;
            if (ar_load && ad_func == 6'o06) napb++;
            if (br_load) nbr++;
            if (done === 1'b1) begin
                lat = c;
                ovf_at_done = int'(div_ovf);
            end
        end
        chk($sformatf("%s latency", v.name), lat, v.lat);
        chk($sformatf("%s ar_load cycles", v.name), nar, v.nar);
        chk($sformatf("%s add cycles", v.name), napb, v.napb);
        chk($sformatf("%s br_load cycles", v.name), nbr, 1);
        chk($sformatf("%s div_ovf at done", v.name), ovf_at_done, int'(v.ovf));
        chk($sformatf("%s per-cycle errors (first at cycle %0d)", v.name, first_bad), err, 0);
        // Following IDLE cycle: quiet outputs, overflow held
        tick();
        start = 1'b0; mq35 = 1'b0; ad_sign = 1'b0; ad_cry0 = 1'b0;
        #1;
        chk($sformatf("%s idle busy/done", v.name), {busy, done}, 0);
        chk($sformatf("%s idle step_cnt", v.name), step_cnt, 0);
        chk($sformatf("%s idle mq_sel", v.name), mq_sel, 3);
        chk($sformatf("%s idle div_ovf held", v.name), div_ovf, int'(v.ovf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        tbl[0] = '{"mul mq=1",      1'b0, 1, 1'b0, 0, 38, 36, 36, 1'b0};
        tbl[1] = '{"mul mq=0",      1'b0, 0, 1'b0, 0, 38, 36,  0, 1'b0};
        tbl[2] = '{"mul mq alt",    1'b0, 2, 1'b0, 0, 38, 36, 18, 1'b0};
        tbl[3] = '{"div ovf",       1'b1, 0, 1'b1, 0,  3,  0,  0, 1'b1};
        tbl[4] = '{"div sign=0",    1'b1, 0, 1'b0, 0, 40, 36,  0, 1'b0};
        tbl[5] = '{"div last neg",  1'b1, 0, 1'b0, 2, 40, 37,  1, 1'b0};
        tbl[6] = '{"div sign=1",    1'b1, 0, 1'b0, 1, 40, 37, 36, 1'b0};
        tbl[7] = '{"div sign alt",  1'b1, 0, 1'b0, 3, 40, 36, 18, 1'b0};

        rst_n = 1'b0; start = 1'b0; op_div = 1'b0; abort = 1'b0;
        mq35 = 1'b0; ad_sign = 1'b0; ad_cry0 = 1'b0;
        #12;
        chk("reset busy/done/ovf", {busy, done, div_ovf}, 0);
        chk("reset loads", {ar_load, arx_load, br_load, brx_load}, 0);
        chk("reset mq_sel", mq_sel, 3);
        chk("reset selects", {ad_func, ada_sel, adb_sel, ar_sel}, 0);
        chk("reset step_cnt", step_cnt, 0);
        #5 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_op(tbl[i]);

        // Reset asserted mid-multiply with 20 steps remaining
        tick(); start = 1'b1; op_div = 1'b0; mq35 = 1'b1; #1;
        for (int c = 1; c <= 17; c++) begin tick(); start = 1'b0; #1; end
        chk("mid-step step_cnt", step_cnt, 20);
        chk("mid-step ar_load", ar_load, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset busy", busy, 0);
        chk("async reset loads", {ar_load, arx_load, br_load, brx_load}, 0);
        chk("async reset mq_sel", mq_sel, 3);
        chk("async reset step_cnt", step_cnt, 0);
        chk("async reset ad_func", ad_func, 0);
        #1 rst_n = 1'b1; mq35 = 1'b0;

        // Abort at STEP 10, then a start in the following IDLE cycle
        tick(); start = 1'b1; op_div = 1'b0; #1;
        for (int c = 1; c <= 12; c++) begin tick(); start = 1'b0; #1; end
        chk("pre-abort step_cnt", step_cnt, 25);
        abort = 1'b1; #1;
        chk("abort ar_load", ar_load, 0);
        chk("abort mq_sel", mq_sel, 3);
        chk("abort busy same cycle", busy, 1);
        tick(); abort = 1'b0; start = 1'b1; op_div = 1'b0; #1;
        chk("after abort busy/done", {busy, done}, 0);
        chk("after abort step_cnt", step_cnt, 0);
        lat = -1;
        for (int c = 1; c < 60 && lat < 0; c++) begin
            tick(); start = 1'b0; #1;
            if (c == 1) chk("restart br_load", {br_load, busy}, 3);
            if (done === 1'b1) lat = c;
        end
        chk("restart latency", lat, 38);

        // abort beats start in the same IDLE cycle
        tick(); start = 1'b1; abort = 1'b1; #1;
        tick(); start = 1'b0; abort = 1'b0; #1;
        chk("start+abort dropped busy", busy, 0);
        chk("start+abort no br_load", br_load, 0);
        tick(); #1;
        chk("start+abort stays idle", {busy, done, ar_load}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
